memoria_resposta: RTL and testbench

- Memory-side responder for the multicycle MIPS core, sitting opposite the control unit and datapath.
- Accepts one read or write request at a time: byte address, size and write data.
- Completes each request after a fixed latency of LATENCY cycles. The default of 2 matches the two fetch/decode wait states the control FSM budgets.
- Provides word, halfword and byte access with big-endian lane placement, flags misaligned accesses, and holds a word-organised storage array.

---
 rtl/mem_pkg.sv | 72 +++++++
 rtl/memoria_resposta_if.sv | 19 +
 rtl/mem_array.sv | 18 +
 rtl/memoria_resposta.sv | 104 ++++++++++
 tb/tb_memoria_resposta.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the memory responder: access sizes, FSM states,
// and big-endian lane extract/merge functions.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic size_e norm_size(input logic [1:0] s);
    case (s)
      2'b01:   return SZ_HALF;
      2'b10:   return SZ_BYTE;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input size_e sz,
                                               input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[1] ? {16'h0, word[15:0]} : {16'h0, word[31:16]};
      SZ_BYTE: begin
        case (off)
          2'd0:    return {24'h0, word[31:24]};
          2'd1:    return {24'h0, word[23:16]};
          2'd2:    return {24'h0, word[15:8]};
          default: return {24'h0, word[7:0]};
        endcase
      end
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input size_e sz, input logic [1:0] off);
    logic [31:0] m;
    m = old;
    case (sz)
      SZ_HALF: begin
        if (off[1]) m[15:0] = wd[15:0];
        else        m[31:16] = wd[15:0];
      end
      SZ_BYTE: begin
        case (off)
          2'd0:    m[31:24] = wd[7:0];
          2'd1:    m[23:16] = wd[7:0];
          2'd2:    m[15:8]  = wd[7:0];
          default: m[7:0]   = wd[7:0];
        endcase
      end
      default: m = wd;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/memoria_resposta_if.sv
// Request/response bus between the core (master) and the memory responder (slave).
interface memoria_resposta_if #(
  parameter int AW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [1:0]    size;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic [31:0]   rdata;
  logic          err;

  modport master (output req, we, addr, size, wdata,
                  input  busy, done, rdata, err);
  modport slave  (input  req, we, addr, size, wdata,
                  output busy, done, rdata, err);
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM: one-cycle registered read, read-first on write.
module mem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wd,
  output logic [31:0]              q
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
    if (re) q <= mem[idx];
  end
endmodule

// File: rtl/memoria_resposta.sv
// Memory-side responder: fixed-latency word/half/byte access, big-endian lanes,
// misalignment and busy-drop error pulses.
module memoria_resposta #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int AW      = 32
) (
  input  logic               clk,
  input  logic               reset,
  memoria_resposta_if.slave  bus
);
  import mem_pkg::*;

  localparam int          IW    = $clog2(DEPTH);
  localparam int          CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned LAST  = LATENCY - 1;
  localparam int unsigned RD_AT = (LATENCY > 1) ? LATENCY - 2 : 0;

  state_e          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            we_q, mis_q;
  size_e           sz_q;
  logic [1:0]      off_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     wd_q, rdata_q;
  logic            err_q;

  logic            accept, in_last, ram_re, ram_we;
  logic [IW-1:0]   idx_in, ram_idx;
  logic [31:0]     ram_q, ram_wd;
  size_e           sz_in;
  logic            unused_addr;

  assign sz_in       = norm_size(bus.size);
  assign idx_in      = bus.addr[IW+1:2];
  assign unused_addr = ^bus.addr[AW-1:IW+2];
  assign accept      = bus.req && (state != WAIT);
  assign in_last     = (state == WAIT) && (cnt == CW'(LAST));

  // RAM data must be valid during the last WAIT cycle, so the read is clocked in on the
  // edge that starts it: the acceptance edge itself when LATENCY is 1.
  assign ram_re  = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == CW'(RD_AT)));
  assign ram_we  = in_last && we_q && !mis_q;
  assign ram_idx = (LATENCY == 1 && !ram_we) ? idx_in : idx_q;
  assign ram_wd  = lane_merge(ram_q, wd_q, sz_q, off_q);

  mem_array #(.DEPTH(DEPTH)) u_array (
    .clk (clk),
    .we  (ram_we),
    .re  (ram_re),
    .idx (ram_idx),
    .wd  (ram_wd),
    .q   (ram_q)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req) state_nx = WAIT;
      WAIT:    if (in_last) state_nx = RESP;
      RESP:    state_nx = bus.req ? WAIT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      sz_q    <= SZ_WORD;
      off_q   <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        we_q  <= bus.we;
        mis_q <= misaligned(sz_in, bus.addr[1:0]);
        sz_q  <= sz_in;
        off_q <= bus.addr[1:0];
        idx_q <= idx_in;
        wd_q  <= bus.wdata;
      end else if (state == WAIT && !in_last) begin
        cnt <= cnt + 1'b1;
      end
      if (in_last && !we_q)
        rdata_q <= mis_q ? '0 : lane_extract(ram_q, sz_q, off_q);
      err_q <= (in_last && mis_q) || ((state == WAIT) && bus.req);
    end
  end

  assign bus.busy  = (state == WAIT);
  assign bus.done  = (state == RESP);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_memoria_resposta.sv
// Scoreboard bench for memoria_resposta: directed requests push expected completions,
// a negedge monitor pops and checks them as done/err appear.
module tb_memoria_resposta;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t dq[$];
  int   drq[$];

  memoria_resposta_if #(.AW(32)) bus ();

  memoria_resposta #(.DEPTH(256), .LATENCY(2), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.done) begin
        if (dq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
        end else begin
          exp_t e;
          e = dq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("err_at_done", {31'b0, bus.err}, {31'b0, e.err});
          chk("busy_at_done", {31'b0, bus.busy}, 32'd0);
          if (e.rd) chk("rdata", bus.rdata, e.data);
        end
      end else if (bus.err) begin
        if (drq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_err: got err=1 expected 0 (t=%0t)", $time);
        end else begin
          chk("drop_err_cycle", cyc, drq.pop_front());
        end
      end
    end
  end

  // Issue one request; expected completion lands two cycles after the accepting edge.
  task automatic start(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input bit track);
    exp_t e;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.size = sz; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    if (track) begin
      e.cyc = cyc + 2; e.rd = !w; e.data = exp_rd; e.err = exp_err;
      dq.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (dq.size() == 0 && drq.size() == 0) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL timeout: got %0d pending expected 0", dq.size() + drq.size());
    dq.delete(); drq.delete();
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                    input logic exp_err);
    start(1'b1, a, sz, wd, 32'd0, exp_err, 1'b1);
    wait_done();
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] exp_rd,
                    input logic exp_err);
    start(1'b0, a, sz, 32'd0, exp_rd, exp_err, 1'b1);
    wait_done();
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.size = 2'b00; bus.wdata = '0;
    #1;
    chk("reset_busy",  {31'b0, bus.busy}, 32'd0);
    chk("reset_done",  {31'b0, bus.done}, 32'd0);
    chk("reset_err",   {31'b0, bus.err},  32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // word write then read
    wr(32'h10, 2'b00, 32'hDEADBEEF, 1'b0);
    rd(32'h10, 2'b00, 32'hDEADBEEF, 1'b0);

    // sub-word merge and extraction
    wr(32'h10, 2'b00, 32'h11223344, 1'b0);
    wr(32'h11, 2'b10, 32'h000000AA, 1'b0);
    rd(32'h10, 2'b00, 32'h11AA3344, 1'b0);
    wr(32'h12, 2'b01, 32'h0000BEEF, 1'b0);
    rd(32'h10, 2'b00, 32'h11AABEEF, 1'b0);
    rd(32'h13, 2'b10, 32'h000000EF, 1'b0);
    rd(32'h10, 2'b01, 32'h000011AA, 1'b0);
    rd(32'h10, 2'b10, 32'h00000011, 1'b0);

    // misaligned accesses and reserved size
    wr(32'h20, 2'b00, 32'h01020304, 1'b0);
    wr(32'h21, 2'b01, 32'h0000FFFF, 1'b1);
    rd(32'h20, 2'b00, 32'h01020304, 1'b0);
    rd(32'h22, 2'b00, 32'h00000000, 1'b1);
    rd(32'h20, 2'b11, 32'h01020304, 1'b0);

    // request during WAIT is dropped with an err pulse
    start(1'b1, 32'h40, 2'b00, 32'h55AA55AA, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10; bus.size = 2'b00;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    drq.push_back(cyc);
    wait_done();
    rd(32'h40, 2'b00, 32'h55AA55AA, 1'b0);

    // read accepted in the write's RESP cycle sees the new data
    start(1'b1, 32'h10, 2'b00, 32'h0BADF00D, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    start(1'b0, 32'h10, 2'b00, 32'd0, 32'h0BADF00D, 1'b0, 1'b1);
    wait_done();

    // reset during a pending write aborts it
    wr(32'h30, 2'b00, 32'hCAFEF00D, 1'b0);
    rd(32'h30, 2'b00, 32'hCAFEF00D, 1'b0);
    start(1'b1, 32'h30, 2'b00, 32'h12345678, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_reset_busy",  {31'b0, bus.busy}, 32'd0);
    chk("mid_reset_done",  {31'b0, bus.done}, 32'd0);
    chk("mid_reset_err",   {31'b0, bus.err},  32'd0);
    chk("mid_reset_rdata", bus.rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(32'h30, 2'b00, 32'hCAFEF00D, 1'b0);

    // address wraps modulo DEPTH*4
    wr(32'h400, 2'b00, 32'hA5A5F00F, 1'b0);
    rd(32'h000, 2'b00, 32'hA5A5F00F, 1'b0);

    repeat (3) @(negedge clk);
    if (dq.size() != 0 || drq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover: got %0d pending expected 0", dq.size() + drq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
